code_nco_ctrl: RTL
==================

# code_nco_ctrl

Sample-rate sequencer and configuration front end for an array of `code_nco` channels in the GPS synthesizer. Holds double-buffered per-channel code frequency, C/A select and enable; applies updates atomically on sample boundaries; issues one `dv_in` strobe per sample period to each enabled NCO; gathers returned chips into one aligned vector for the downstream modulator.

## Interface
- `NUM_CHAN`, 4, number of code NCO channels (1..32)
- `SAMPLE_CLKS`, 64, clocks per output sample (>= 8)
- `clk`  input  1  system clock
- `reset`  input  1  asynchronous, active-low reset
- `run`  input  1  level; enables sample strobes, sampled only at boundary
- `cfg_we`  input  1  write `cfg_*` into shadow of channel `cfg_chan`
- `cfg_chan`  input  $clog2(NUM_CHAN)  target channel
- `cfg_freq`  input  32  code phase increment
- `cfg_ca_sel`  input  6  PRN select
- `cfg_en`  input  1  channel enable
- `apply`  input  1  pulse; request shadow→active copy at next boundary
- `apply_pending`  output  1  copy requested, not yet done
- `nco_dv_in`  output  NUM_CHAN  per-channel sample strobe
- `nco_freq`  output  NUM_CHAN*32  active frequencies, channel i at [32i+:32]
- `nco_ca_sel`  output  NUM_CHAN*6  active PRN selects
- `nco_dv_out`  input  NUM_CHAN  per-channel chip valid
- `nco_q`  input  NUM_CHAN  per-channel chip
- `chips`  output  NUM_CHAN  collected chips, disabled channels 0
- `chips_valid`  output  1  one-cycle pulse, `chips` complete
- `err_late`  output  1  sticky: enabled channel missed its period
- `err_clr`  input  1  clears `err_late`

## Operation
- `cnt` free-runs 0..SAMPLE_CLKS-1, wraps to 0 regardless of `run`. Boundary = cycle with `cnt==0`.
- FSM: IDLE, STROBE, COLLECT, HOLD.
- Boundary cycle (any state): if `apply_pending`, active ← shadow for all channels and pending clears; `apply` in the same cycle re-sets pending (new request, next boundary). `cfg_we` in the boundary cycle lands in shadow after the copy (not included).
- Boundary with `run`=1 and ≥1 active-enabled channel → STROBE; otherwise → IDLE.
- STROBE (`cnt==1`): `nco_dv_in[i]`=1 for one cycle for each active-enabled i; clear `got` mask and chip capture; → COLLECT.
- COLLECT: on `nco_dv_out[i]` for enabled i, capture `nco_q[i]`, set `got[i]`. When `got`==enabled mask → `chips_valid` pulse next cycle with all captured chips, → HOLD. Repeated/disabled-channel `dv_out` ignored.
- COLLECT reaching boundary with mask incomplete: set `err_late`, no `chips_valid`, normal boundary processing.
- HOLD: wait for boundary. IDLE: no strobes, `dv_out` ignored.
- `run` falling mid-period: current period completes; stop at next boundary.
- `cfg_we` and `apply` legal any cycle; shadow writes never disturb active.
- `err_clr` and late event same cycle: set wins.
- Mid-operation reset: all state to reset values immediately.

## Timing
- Reset values: `cnt`=0, state IDLE, all shadow/active fields 0 (all channels disabled), `apply_pending`=0, `nco_dv_in`=0, `chips`=0, `chips_valid`=0, `err_late`=0.
- All outputs registered.
- Active config visible on `nco_freq`/`nco_ca_sel` from `cnt==1`, same cycle as the strobe: NCO samples the new value on the first strobe after the copy.
- `apply_pending` rises the cycle after `apply`, falls the cycle after the boundary copy.
- `chips_valid` asserts 1 cycle after the last required `dv_out`; at most once per period.
- NCO return latency budget: `dv_out` must arrive by `cnt==SAMPLE_CLKS-1`.

## Structure
- Package `code_ctrl_pkg`: `FREQ_W`=32, `CA_SEL_W`=6, `chan_cfg_t` struct {freq, ca_sel, en}, FSM state enum.
- Sub-module `code_chan_regs`: one channel's shadow/active `chan_cfg_t` pair with write and copy enables; instantiated NUM_CHAN times by generate.
- `code_nco_ctrl` holds counter, FSM, collection mask, error flag.

## Test plan
- Reset then idle: `run`=0, 200 cycles → `nco_dv_in` never set, all outputs 0.
- Ch1 `freq`=32'h27456789, `ca_sel`=3, en, `apply`, `run`=1 → `nco_freq[63:32]` changes at `cnt==1`, `nco_dv_in`=4'b0010 every 64 cycles, `chips_valid` each period with `chips[1]`=model chip.
- Mid-run write ch1 `freq`=32'h12468ace without `apply` → active unchanged; `apply` → new value from next `cnt==1`, first strobe uses it.
- `cfg_we`+`apply` both in boundary cycle → not copied that boundary; copied next; `apply_pending` high for one full period.
- Four channels enabled, stub ch2 `dv_out` withheld → no `chips_valid`, `err_late`=1 at boundary; `err_clr` → 0; stub restored → `chips_valid` resumes.
- Drop `run` at `cnt==30` → period finishes with `chips_valid`, no strobe afterwards; async reset at `cnt==20` → all outputs 0 same cycle.

Source files
------------

// File: rtl/code_ctrl_pkg.sv
// Shared types for the code NCO controller: per-channel configuration record and FSM states.
package code_ctrl_pkg;

    localparam int FREQ_W   = 32;
    localparam int CA_SEL_W = 6;
    localparam int CFG_W    = FREQ_W + CA_SEL_W + 1;

    typedef struct packed {
        logic [FREQ_W-1:0]   freq;
        logic [CA_SEL_W-1:0] ca_sel;
        logic                en;
    } chan_cfg_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        COLLECT = 2'd2,
        HOLD    = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/code_chan_regs.sv
// One channel's double-buffered configuration: shadow takes host writes, active feeds the NCO.
module code_chan_regs
    import code_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             copy,
    input  logic [CFG_W-1:0] wr_cfg,
    output logic             shadow_en,
    output logic [CFG_W-1:0] active
);

    chan_cfg_t shadow_q;
    chan_cfg_t active_q;

    // Copy reads the old shadow, so a write in the copy cycle waits for the next apply.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (copy)
                active_q <= shadow_q;
            if (we)
                shadow_q <= chan_cfg_t'(wr_cfg);
        end
    end

    assign shadow_en = shadow_q.en;
    assign active    = active_q;

endmodule

// File: rtl/code_nco_ctrl.sv
// Sample-rate sequencer for an array of code NCOs: atomic config apply, per-period strobe,
// chip collection into one aligned vector, and late-return detection.
module code_nco_ctrl
    import code_ctrl_pkg::*;
#(
    parameter  int NUM_CHAN    = 4,
    parameter  int SAMPLE_CLKS = 64,
    localparam int CHAN_W      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         cfg_we,
    input  logic [CHAN_W-1:0]            cfg_chan,
    input  logic [FREQ_W-1:0]            cfg_freq,
    input  logic [CA_SEL_W-1:0]          cfg_ca_sel,
    input  logic                         cfg_en,
    input  logic                         apply,
    output logic                         apply_pending,
    output logic [NUM_CHAN-1:0]          nco_dv_in,
    output logic [NUM_CHAN*FREQ_W-1:0]   nco_freq,
    output logic [NUM_CHAN*CA_SEL_W-1:0] nco_ca_sel,
    input  logic [NUM_CHAN-1:0]          nco_dv_out,
    input  logic [NUM_CHAN-1:0]          nco_q,
    output logic [NUM_CHAN-1:0]          chips,
    output logic                         chips_valid,
    output logic                         err_late,
    input  logic                         err_clr
);

    localparam int               CNT_W    = $clog2(SAMPLE_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CLKS - 1);

    logic [CNT_W-1:0]    cnt;
    ctrl_state_t         state, state_next;
    logic [NUM_CHAN-1:0] got, got_next, got_upd;
    logic [NUM_CHAN-1:0] cap, cap_next, cap_upd;
    logic [NUM_CHAN-1:0] fresh;
    logic [NUM_CHAN-1:0] dv_in_next, chips_next;
    logic                cv_next, late_set;
    logic                boundary, do_copy;
    logic [NUM_CHAN-1:0] en_act, en_sh, en_next;
    chan_cfg_t           wr_cfg;

    assign boundary = (cnt == '0);
    assign do_copy  = boundary & apply_pending;
    assign wr_cfg   = '{freq: cfg_freq, ca_sel: cfg_ca_sel, en: cfg_en};

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        chan_cfg_t act;
        logic      sh_en;

        code_chan_regs u_regs (
            .clk       (clk),
            .reset     (reset),
            .we        (cfg_we && (cfg_chan == CHAN_W'(i))),
            .copy      (do_copy),
            .wr_cfg    (wr_cfg),
            .shadow_en (sh_en),
            .active    (act)
        );

        assign en_act[i]                      = act.en;
        assign en_sh[i]                       = sh_en;
        assign nco_freq[FREQ_W*i +: FREQ_W]   = act.freq;
        assign nco_ca_sel[CA_SEL_W*i +: CA_SEL_W] = act.ca_sel;
    end

    // Enables as they will be once this boundary's copy has landed.
    assign en_next = do_copy ? en_sh : en_act;

    // Only the first dv_out of an enabled channel in a period counts.
    assign fresh   = nco_dv_out & en_act & ~got;
    assign got_upd = got | fresh;
    assign cap_upd = cap | (nco_q & fresh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        dv_in_next = '0;
        got_next   = got;
        cap_next   = cap;
        chips_next = chips;
        cv_next    = 1'b0;
        late_set   = 1'b0;
        case (state)
            STROBE: begin
                got_next   = '0;
                cap_next   = '0;
                state_next = COLLECT;
            end
            COLLECT: begin
                got_next = got_upd;
                cap_next = cap_upd;
                if (got_upd == en_act) begin
                    cv_next    = 1'b1;
                    chips_next = cap_upd;
                    state_next = HOLD;
                end
            end
            default: ;
        endcase
        // The boundary overrides everything: an unfinished collection is late, never valid.
        if (boundary) begin
            late_set   = (state == COLLECT);
            cv_next    = 1'b0;
            chips_next = chips;
            if (run && (en_next != '0)) begin
                state_next = STROBE;
                dv_in_next = en_next;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            apply_pending <= 1'b0;
            nco_dv_in     <= '0;
            got           <= '0;
            cap           <= '0;
            chips         <= '0;
            chips_valid   <= 1'b0;
            err_late      <= 1'b0;
        end else begin
            cnt           <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            apply_pending <= apply | (apply_pending & ~boundary);
            nco_dv_in     <= dv_in_next;
            got           <= got_next;
            cap           <= cap_next;
            chips         <= chips_next;
            chips_valid   <= cv_next;
            err_late      <= late_set | (err_late & ~err_clr);
        end
    end

endmodule
